// File: rtl/state_dump_tx.sv
// On EBREAK in the memory stage: freeze the core, then stream PC and x0..x31 as 33 valid/ready beats.
// The first beat is valid 1 cycle after detection. Each beat holds stable under backpressure, and done is sticky until rst.
module state_dump_tx #(
    parameter int              XLEN       = 32,
    parameter int              NREGS      = 32,
    parameter logic [XLEN-1:0] HALT_INSTR = 32'h00100073
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] instr_m,
    input  logic [XLEN-1:0] pc_f,
    output logic [4:0]      rf_raddr,
    input  logic [XLEN-1:0] rf_rdata,
    output logic            halt,
    output logic            dump_valid,
    input  logic            dump_ready,
    output logic [XLEN-1:0] dump_data,
    output logic [5:0]      dump_idx,
    output logic            dump_last,
    output logic            done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [5:0] LAST_IDX = 6'(NREGS);

    state_t state;

    // Beat k carries x(k-1), so the read port looks up the register for the next beat.
    // On beat 32 this wraps to 0, and that read is never used.
    assign rf_raddr = (state == SEND) ? dump_idx[4:0] : 5'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            halt       <= 1'b0;
            dump_valid <= 1'b0;
            dump_data  <= '0;
            dump_idx   <= '0;
            dump_last  <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (instr_m == HALT_INSTR) begin
                        state      <= SEND;
                        halt       <= 1'b1;
                        dump_valid <= 1'b1;
                        dump_data  <= pc_f;
                        dump_idx   <= '0;
                        dump_last  <= 1'b0;
                    end
                end
                SEND: begin
                    if (dump_valid && dump_ready) begin
                        if (dump_idx == LAST_IDX) begin
                            state      <= DONE;
                            dump_valid <= 1'b0;
                            dump_last  <= 1'b0;
                            done       <= 1'b1;
                        end else begin
                            dump_data <= rf_rdata;
                            dump_idx  <= dump_idx + 6'd1;
                            dump_last <= (dump_idx + 6'd1 == LAST_IDX);
                        end
                    end
                end
                DONE: begin
                    halt <= 1'b1;
                    done <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_state_dump_tx.sv
// Directed bench for state_dump_tx: a register-file model answers the read port, and each accepted beat is checked against it.
module tb_state_dump_tx;

    localparam logic [31:0] HALT = 32'h00100073;
    localparam logic [31:0] NOP  = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_m;
    logic [31:0] pc_f;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic        halt;
    logic        dump_valid;
    logic        dump_ready;
    logic [31:0] dump_data;
    logic [5:0]  dump_idx;
    logic        dump_last;
    logic        done;

    logic [31:0] rf_model [32];
    logic [31:0] exp_pc;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    assign rf_rdata = rf_model[rf_raddr];

    state_dump_tx dut (
        .clk        (clk),
        .rst        (rst),
        .instr_m    (instr_m),
        .pc_f       (pc_f),
        .rf_raddr   (rf_raddr),
        .rf_rdata   (rf_rdata),
        .halt       (halt),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_data  (dump_data),
        .dump_idx   (dump_idx),
        .dump_last  (dump_last),
        .done       (done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_beat(input int k);
        return (k == 0) ? exp_pc : rf_model[k-1];
    endfunction

    task automatic preload();
        for (int i = 0; i < 32; i++) rf_model[i] = 32'h0;
        rf_model[1]  = 32'h00000005;
        rf_model[2]  = 32'hFFFFFFFF;
        rf_model[31] = 32'h00000007;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        instr_m = NOP;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_halt"}, 32'(halt), 32'd0);
        check_eq({tag, "_vld"},  32'(dump_valid), 32'd0);
        check_eq({tag, "_dat"},  dump_data, 32'd0);
        check_eq({tag, "_idx"},  32'(dump_idx), 32'd0);
        check_eq({tag, "_last"}, 32'(dump_last), 32'd0);
        check_eq({tag, "_done"}, 32'(done), 32'd0);
        check_eq({tag, "_raddr"}, 32'(rf_raddr), 32'd0);
    endtask

    // Present HALT for one edge, then confirm the PC beat appears on the next cycle.
    task automatic start_dump(input logic [31:0] pc);
        exp_pc  = pc;
        pc_f    = pc;
        instr_m = HALT;
        tick();
        instr_m = NOP;
        pc_f    = 32'hDEAD0000;
        check_eq("start_halt", 32'(halt), 32'd1);
        check_eq("start_vld",  32'(dump_valid), 32'd1);
        check_eq("start_idx",  32'(dump_idx), 32'd0);
        check_eq("start_dat",  dump_data, pc);
    endtask

    // mode 0: ready=1; mode 1: ready 1,0,0,1 repeating; mode 2: ready=0 for stall0 cycles, then 1.
    task automatic run_stream(input int mode, input int stall0, input int halt_at,
                              input int stop_after, output int beats, output int cycles);
        logic        prev_stall;
        logic [31:0] prev_dat;
        logic [5:0]  prev_idx;
        beats      = 0;
        cycles     = 0;
        prev_stall = 1'b0;
        prev_dat   = '0;
        prev_idx   = '0;
        while (beats < 33 && beats != stop_after && cycles < 2000) begin
            case (mode)
                1:       dump_ready = (cycles % 4 == 0) || (cycles % 4 == 3);
                2:       dump_ready = (cycles >= stall0);
                default: dump_ready = 1'b1;
            endcase
            instr_m = (beats == halt_at) ? HALT : NOP;
            check_eq("s_vld",  32'(dump_valid), 32'd1);
            check_eq("s_halt", 32'(halt), 32'd1);
            if (prev_stall) begin
                check_eq("hold_dat", dump_data, prev_dat);
                check_eq("hold_idx", 32'(dump_idx), 32'(prev_idx));
            end
            if (dump_valid && dump_ready) begin
                check_eq("beat_idx",  32'(dump_idx), 32'(beats));
                check_eq("beat_dat",  dump_data, exp_beat(beats));
                check_eq("beat_last", 32'(dump_last), 32'(beats == 32));
                if (beats < 32) check_eq("raddr", 32'(rf_raddr), 32'(beats));
                beats++;
            end
            prev_stall = dump_valid && !dump_ready;
            prev_dat   = dump_data;
            prev_idx   = dump_idx;
            tick();
            cycles++;
        end
        instr_m = NOP;
        if (stop_after < 0) check_eq("beat_count", 32'(beats), 32'd33);
    endtask

    task automatic check_done(input string tag);
        check_eq({tag, "_done"}, 32'(done), 32'd1);
        check_eq({tag, "_halt"}, 32'(halt), 32'd1);
        check_eq({tag, "_vld"},  32'(dump_valid), 32'd0);
        check_eq({tag, "_last"}, 32'(dump_last), 32'd0);
    endtask

    initial begin
        int beats;
        int cycles;
        rst        = 1'b1;
        instr_m    = NOP;
        pc_f       = 32'h0;
        dump_ready = 1'b0;
        exp_pc     = 32'h0;
        preload();
        do_reset();
        check_idle_outputs("reset");

        // Full-rate dump: 33 beats in 33 consecutive cycles.
        dump_ready = 1'b1;
        start_dump(32'h0000004C);
        run_stream(0, 0, -1, -1, beats, cycles);
        check_eq("t1_cycles", 32'(cycles), 32'd33);
        check_done("t1");

        // Ready pattern 1,0,0,1: 16 full groups plus one beat.
        do_reset();
        start_dump(32'h0000004C);
        run_stream(1, 0, -1, -1, beats, cycles);
        check_eq("t2_cycles", 32'(cycles), 32'd65);
        check_done("t2");

        // No HALT for 250 cycles.
        do_reset();
        dump_ready = 1'b1;
        for (int i = 0; i < 250; i++) begin
            instr_m = $urandom;
            if (instr_m == HALT) instr_m = NOP;
            tick();
            check_eq("t3_halt", 32'(halt), 32'd0);
            check_eq("t3_vld",  32'(dump_valid), 32'd0);
            check_eq("t3_done", 32'(done), 32'd0);
        end
        instr_m = NOP;

        // Reset after beat idx10 is accepted, then a fresh dump.
        start_dump(32'h00001000);
        run_stream(0, 0, -1, 11, beats, cycles);
        check_eq("t4_beats", 32'(beats), 32'd11);
        check_eq("t4_idx_pre", 32'(dump_idx), 32'd11);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle_outputs("t4_rst");
        tick();
        check_idle_outputs("t4_idle");
        start_dump(32'h00002000);
        run_stream(0, 0, -1, -1, beats, cycles);
        check_done("t4");

        // HALT during SEND at idx5 and during DONE.
        do_reset();
        start_dump(32'h0000004C);
        run_stream(0, 0, 5, -1, beats, cycles);
        check_eq("t5_cycles", 32'(cycles), 32'd33);
        check_done("t5");
        instr_m = HALT;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_done("t5_rehalt");
            check_eq("t5_idx", 32'(dump_idx), 32'd32);
        end
        instr_m = NOP;

        // Stall PC beat for 20 cycles, then back-to-back.
        do_reset();
        dump_ready = 1'b0;
        start_dump(32'h0000ABCC);
        run_stream(2, 20, -1, -1, beats, cycles);
        check_eq("t6_cycles", 32'(cycles), 32'd53);
        check_done("t6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/state_dump_tx.md
Name: state_dump_tx

Overview:
Hardware producer of the core's end-of-run architectural state. It watches the memory-stage instruction for the halt encoding (EBREAK, 32'h00100073) and freezes the core. It then streams PC followed by x0..x31 over a valid/ready interface to a logger or host link. It sits beside the core's register file and uses a dedicated register-file read port.

Parameters:
XLEN, 32, data width of PC and registers
NREGS, 32, number of architectural registers streamed after PC
HALT_INSTR, 32'h00100073, instruction encoding that triggers a dump

Ports:
clk  input  1  core clock
rst  input  1  synchronous reset, active-high
instr_m  input  XLEN  instruction currently in memory stage
pc_f  input  XLEN  fetch-stage PC
rf_raddr  output  5  register-file read address (combinational read)
rf_rdata  input  XLEN  register-file read data for rf_raddr, same cycle
halt  output  1  freeze request to core pipeline
dump_valid  output  1  beat valid
dump_ready  input  1  sink accepts beat
dump_data  output  XLEN  beat payload
dump_idx  output  6  0 = PC, k = x(k-1) for k in 1..32
dump_last  output  1  high on final beat (idx 32)
done  output  1  dump complete, sticky until rst

Behaviour:
- Reset values: halt=0, dump_valid=0, dump_data=0, dump_idx=0, dump_last=0, done=0, rf_raddr=0, state=IDLE.
- rst has priority over all events in every state, including mid-stream. The next state is IDLE with all outputs at their reset values. No partial beat is preserved.
- FSM states: IDLE, SEND, DONE.
- IDLE:
  - If instr_m==HALT_INSTR at a posedge, the next cycle has state=SEND, halt=1, dump_valid=1, dump_idx=0, and dump_data = pc_f sampled at that edge.
  - Latency from detection edge to first valid beat is 1 cycle.
- SEND, holding beat k:
  - rf_raddr = k (the register for beat k+1). For k=32, rf_raddr=0 (don't-care).
  - Handshake occurs when dump_valid & dump_ready at a posedge.
  - Without a handshake, dump_data, dump_idx and dump_last hold stable and dump_valid stays 1. Valid is never withdrawn before acceptance.
  - On a handshake with k<32: dump_data <= rf_rdata, dump_idx <= k+1, dump_last <= (k+1==32).
  - On a handshake with k==32: dump_valid <= 0, dump_last <= 0, state <= DONE.
- DONE: done=1, halt=1, dump_valid=0. Stays until rst.
- halt is asserted continuously from the first SEND cycle through DONE. The core must not write the register file while halt=1.
- x0 is streamed as read from the register file; it must read 0.
- instr_m==HALT_INSTR is ignored outside IDLE. A repeated halt during SEND or DONE restarts nothing.
- Throughput: with dump_ready held at 1, the 33 beats occupy 33 consecutive cycles.
- Widths: dump_idx is 6 bits, range 0..32, and never wraps. rf_raddr = dump_idx[4:0] in SEND.

Test Plan:
1. Preload x1=5, x2=32'hFFFFFFFF, x31=7 and all others 0. pc_f=32'h0000004C when instr_m=HALT_INSTR, dump_ready=1.
   -> halt rises 1 cycle later.
   -> 33 consecutive beats: idx0=0000004C, idx2=5, idx3=FFFFFFFF, idx32=7, all other beats 0.
   -> dump_last only on idx32; done=1 the cycle after.
2. Same setup with dump_ready toggling 1,0,0,1 repeatedly.
   -> Each beat's data and idx are held unchanged while ready=0.
   -> 33 handshakes total, no beat duplicated or skipped.
3. instr_m never equal to HALT_INSTR for 250 cycles.
   -> halt, dump_valid and done stay 0 throughout.
4. rst pulsed for 1 cycle after beat idx10 is accepted.
   -> Next cycle: state IDLE, dump_valid=0, halt=0, idx=0.
   -> A later HALT_INSTR starts a fresh dump at idx0.
5. HALT_INSTR presented again during SEND (at idx5) and during DONE.
   -> Stream continues unperturbed to idx32.
   -> done stays 1 and no new beats appear.
6. dump_ready=0 for 20 cycles on beat idx0, then 1.
   -> dump_data stays PC for all 20 cycles; the remaining beats follow back-to-back.
